// File: rtl/ex_stage.sv
// MIPS execute stage: logic/shift/arith/move ALU, HI/LO registers, single-cycle
// multiplier and a restoring radix-2 divider that stalls the front end while busy.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_reg1,
  input  logic [31:0] ex_reg2,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [2:0]  ex_alusel,
  input  logic [7:0]  ex_aluop,
  output logic [4:0]  wd,
  output logic        wreg,
  output logic [31:0] wdata,
  output logic        stallreq
);
  localparam logic [2:0] SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_ARITH = 3'd3,
                         SEL_MOVE  = 3'd4, SEL_MULDIV = 3'd5;
  localparam logic [7:0] OP_AND  = 8'h24, OP_OR   = 8'h25, OP_XOR  = 8'h26, OP_NOR  = 8'h27,
                         OP_SLL  = 8'h00, OP_SRL  = 8'h02, OP_SRA  = 8'h03,
                         OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLT  = 8'h2A, OP_SLTU = 8'h2B,
                         OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12, OP_MTLO = 8'h13,
                         OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

  div_state_t  state;
  logic [31:0] hi, lo;
  logic [5:0]  cnt;
  logic [31:0] dvd, dvs, rem;
  logic        neg_q, neg_r, dbz;

  logic [31:0] alu_res;
  logic        wreg_c, is_mthi, is_mtlo, is_mul, is_mul_s, is_div, is_div_s;

  always_comb begin
    alu_res  = '0;
    wreg_c   = ex_wreg;
    is_mthi  = 1'b0;
    is_mtlo  = 1'b0;
    is_mul   = 1'b0;
    is_mul_s = 1'b0;
    is_div   = 1'b0;
    is_div_s = 1'b0;
    case (ex_alusel)
      SEL_LOGIC: case (ex_aluop)
        OP_AND:  alu_res = ex_reg1 & ex_reg2;
        OP_OR:   alu_res = ex_reg1 | ex_reg2;
        OP_XOR:  alu_res = ex_reg1 ^ ex_reg2;
        OP_NOR:  alu_res = ~(ex_reg1 | ex_reg2);
        default: ;
      endcase
      SEL_SHIFT: case (ex_aluop)
        OP_SLL:  alu_res = ex_reg2 << ex_reg1[4:0];
        OP_SRL:  alu_res = ex_reg2 >> ex_reg1[4:0];
        OP_SRA:  alu_res = $signed(ex_reg2) >>> ex_reg1[4:0];
        default: ;
      endcase
      SEL_ARITH: case (ex_aluop)
        OP_ADDU: alu_res = ex_reg1 + ex_reg2;
        OP_SUBU: alu_res = ex_reg1 - ex_reg2;
        OP_SLT:  alu_res = {31'd0, $signed(ex_reg1) < $signed(ex_reg2)};
        OP_SLTU: alu_res = {31'd0, ex_reg1 < ex_reg2};
        default: ;
      endcase
      SEL_MOVE: case (ex_aluop)
        OP_MFHI: alu_res = hi;
        OP_MFLO: alu_res = lo;
        OP_MTHI: begin is_mthi = 1'b1; wreg_c = 1'b0; end
        OP_MTLO: begin is_mtlo = 1'b1; wreg_c = 1'b0; end
        default: ;
      endcase
      SEL_MULDIV: case (ex_aluop)
        OP_MULT:  begin is_mul = 1'b1; is_mul_s = 1'b1; wreg_c = 1'b0; end
        OP_MULTU: begin is_mul = 1'b1; wreg_c = 1'b0; end
        OP_DIV:   begin is_div = 1'b1; is_div_s = 1'b1; wreg_c = 1'b0; end
        OP_DIVU:  begin is_div = 1'b1; wreg_c = 1'b0; end
        default: ;
      endcase
      default: ;
    endcase
  end

  // Sign-extend to 64 bits for MULT so the low 64 bits of the unsigned product are correct.
  logic [63:0] mul_a, mul_b, prod;
  assign mul_a = {{32{is_mul_s & ex_reg1[31]}}, ex_reg1};
  assign mul_b = {{32{is_mul_s & ex_reg2[31]}}, ex_reg2};
  assign prod  = mul_a * mul_b;

  logic [31:0] abs1, abs2, q_fix, r_fix;
  assign abs1 = (is_div_s & ex_reg1[31]) ? -ex_reg1 : ex_reg1;
  assign abs2 = (is_div_s & ex_reg2[31]) ? -ex_reg2 : ex_reg2;
  assign q_fix = neg_q ? -dvd : dvd;
  assign r_fix = neg_r ? -rem : rem;

  // Restoring step: dvd shifts out dividend bits and collects quotient bits.
  logic [32:0] trial;
  logic        ge;
  assign trial = {rem, dvd[31]} - {1'b0, dvs};
  assign ge    = ~trial[32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mthi) hi <= ex_reg1;
          if (is_mtlo) lo <= ex_reg1;
          if (is_mul) {hi, lo} <= prod;
          if (is_div) begin
            dvd   <= abs1;
            dvs   <= abs2;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= is_div_s & (ex_reg1[31] ^ ex_reg2[31]);
            neg_r <= is_div_s & ex_reg1[31];
            dbz   <= (ex_reg2 == 32'd0);
            state <= (ex_reg2 == 32'd0) ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          dvd <= {dvd[30:0], ge};
          rem <= ge ? trial[31:0] : {rem[30:0], dvd[31]};
          cnt <= cnt + 6'd1;
          if (cnt == 6'(DIV_CYCLES - 1)) state <= S_DONE;
        end
        S_DONE: begin
          if (!dbz) begin
            hi <= r_fix;
            lo <= q_fix;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wd       = rst ? 5'd0 : ex_wd;
  assign wreg     = rst ? 1'b0 : wreg_c;
  assign wdata    = rst ? 32'd0 : alu_res;
  assign stallreq = ~rst & ((state == S_IDLE && is_div) || state == S_BUSY);
endmodule
